// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage forwarding muxes feeding the ALU.
// Also raises the load-use stall and inserts the matching bubble.
module id_ex_operand_stage #(
    parameter int DATA_WIDTH     = 64,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [ALU_CTRL_WIDTH-1:0] id_alu_control,
    input  logic [1:0]                id_src_a_sel,
    input  logic                      id_src_b_sel,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      flush,
    input  logic                      hold,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     wb_result,
    output logic                      id_stall,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [DATA_WIDTH-1:0]     ex_operand_a,
    output logic [DATA_WIDTH-1:0]     ex_operand_b,
    output logic [ALU_CTRL_WIDTH-1:0] ex_alu_control,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write
);

    logic [DATA_WIDTH-1:0]     rs1_q, rs2_q, imm_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q, rs2_addr_q;
    logic [1:0]                src_a_sel_q;
    logic                      src_b_sel_q;

    logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic wb_cap1, wb_cap2, load_use, clear_ex;
    logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2, cap_rs1, cap_rs2;

    // x0 is never a forwarding source, hence the non-zero address checks.
    assign mem_hit1 = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs1_addr_q);
    assign mem_hit2 = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs2_addr_q);
    assign wb_hit1  = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr_q);
    assign wb_hit2  = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr_q);

    assign fwd_rs1 = mem_hit1 ? mem_result : (wb_hit1 ? wb_result : rs1_q);
    assign fwd_rs2 = mem_hit2 ? mem_result : (wb_hit2 ? wb_result : rs2_q);

    // Same-cycle register-file write/read: take the WB value at capture.
    assign wb_cap1 = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs1_addr);
    assign wb_cap2 = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs2_addr);
    assign cap_rs1 = wb_cap1 ? wb_result : id_rs1_data;
    assign cap_rs2 = wb_cap2 ? wb_result : id_rs2_data;

    assign load_use = ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    assign id_stall = load_use && id_valid && !flush;

    // Flush beats hold; a load-use bubble only happens when not held.
    assign clear_ex = rst || flush || (!hold && id_stall);

    always_ff @(posedge clk) begin
        if (clear_ex) begin
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rs1_addr_q     <= '0;
            rs2_addr_q     <= '0;
            imm_q          <= '0;
            ex_alu_control <= '0;
            src_a_sel_q    <= '0;
            src_b_sel_q    <= 1'b0;
            ex_rd_addr     <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
        end else if (hold) begin
            // Refresh operands so a producer retiring mid-hold is not lost.
            rs1_q <= fwd_rs1;
            rs2_q <= fwd_rs2;
        end else begin
            ex_valid       <= id_valid;
            ex_pc          <= id_pc;
            rs1_q          <= cap_rs1;
            rs2_q          <= cap_rs2;
            rs1_addr_q     <= id_rs1_addr;
            rs2_addr_q     <= id_rs2_addr;
            imm_q          <= id_imm;
            ex_alu_control <= id_alu_control;
            src_a_sel_q    <= id_src_a_sel;
            src_b_sel_q    <= id_src_b_sel;
            ex_rd_addr     <= id_rd_addr;
            ex_reg_write   <= id_valid && id_reg_write;
            ex_mem_read    <= id_valid && id_mem_read;
            ex_mem_write   <= id_valid && id_mem_write;
        end
    end

    always_comb begin
        ex_operand_a = '0;
        case (src_a_sel_q)
            2'b00:   ex_operand_a = fwd_rs1;
            2'b01:   ex_operand_a = ex_pc;
            default: ex_operand_a = '0;
        endcase
    end

    assign ex_operand_b  = src_b_sel_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule
